// File: rtl/adder_pkg.sv
// Shared definitions for the adder result path.
// The result word is {carry, sum}. The carry sits at the MSB and the sum
// fills the low WIDTH bits.
package adder_pkg;

  // Default sum width of the upstream n_bit_adder
  localparam int ADDER_WIDTH = 8;

  // Width of one stored result word for a given sum width
  function automatic int result_w(input int sum_w);
    return sum_w + 1;
  endfunction

  // Bit position of the carry inside a result word
  function automatic int carry_idx(input int sum_w);
    return sum_w;
  endfunction

  // Result word layout at the default width
  typedef struct packed {
    logic                   carry;
    logic [ADDER_WIDTH-1:0] sum;
  } adder_result_t;

endpackage

// File: rtl/adder_fifo_mem.sv
// Storage array for adder_result_fifo.
// It has DEPTH words of DW bits, one write port and one asynchronous read
// port. The contents are not reset; the pointer logic decides which words
// are valid.
module adder_fifo_mem #(
  parameter int DW    = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write the addressed word on an accepted push
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read of the head word
  assign rdata = mem[raddr];

endmodule

// File: rtl/adder_result_fifo.sv
// adder_result_fifo: buffers {carry, sum} results from an n_bit_adder.
// Optional feature macro: ADDER_FIFO_CARRY_STATS_EN enables the saturating
// carry_cnt statistic. When the macro is undefined, carry_cnt is tied to 0.
//
// Handshake:
//   - Output side: out_valid means the FIFO is non-empty and out_data holds
//     the head word. A pop happens on a rising edge where
//     out_valid && out_ready. out_valid does not depend on out_ready.
//   - Input side: there is no back-pressure. A word offered with in_valid
//     is stored if the FIFO is not full or a pop happens in the same cycle.
//     Otherwise the word is dropped and the sticky overflow flag is set.
//   - clr flushes the FIFO synchronously and has priority over push and pop.
module adder_result_fifo
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         s_in,
  input  logic                     c_in,
  output logic [result_w(WIDTH)-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  output logic [15:0]              carry_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = result_w(WIDTH);

  // Stop elaboration if the depth cannot use the wrap-bit pointer scheme
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("adder_result_fifo: DEPTH must be a power of two >= 2");
  end

  // Pointers carry one extra wrap bit, so they count modulo 2*DEPTH
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          push;
  logic          pop;
  logic [RW-1:0] wr_data;
  logic          overflow_q;

  // Same index and different wrap bit means full. Equal pointers mean empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // When full, a pop in the same cycle frees the head slot for this push.
  assign push      = in_valid && (!full || pop);
  assign level     = wr_ptr - rd_ptr;
  assign overflow  = overflow_q;

  // Pack the adder outputs into the result word, carry at the MSB
  always_comb begin
    wr_data                   = '0;
    wr_data[WIDTH-1:0]        = s_in;
    wr_data[carry_idx(WIDTH)] = c_in;
  end

  adder_fifo_mem #(
    .DW    (RW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !clr),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (out_data)
  );

  // Advance the pointers on accepted push and pop. clr resets both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Sticky overflow: set only when a word is dropped (full and no pop)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (clr) begin
      overflow_q <= 1'b0;
    end else if (in_valid && full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

`ifdef ADDER_FIFO_CARRY_STATS_EN
  logic [15:0] carry_cnt_q;

  // Count accepted pushes that carry out. The count saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt_q <= '0;
    end else if (clr) begin
      carry_cnt_q <= '0;
    end else if (push && c_in && (carry_cnt_q != 16'hFFFF)) begin
      carry_cnt_q <= carry_cnt_q + 16'd1;
    end
  end

  assign carry_cnt = carry_cnt_q;
`else
  assign carry_cnt = 16'd0;
`endif

endmodule

// File: doc/adder_result_fifo.md
ADDER_RESULT_FIFO -- requirements
Module: adder_result_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the sum width, equal to the upstream n_bit_adder WIDTH.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the entry count; a power of two, at least 2.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, the single clock, rising-edge active.
REQ-005 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port clr, input, 1, a synchronous flush.
REQ-007 SHALL have port in_valid, input, 1, meaning s_in/c_in carry a new adder result this cycle.
REQ-008 SHALL have port s_in, input, WIDTH, the adder sum s.
REQ-009 SHALL have port c_in, input, 1, the adder carry-out c.
REQ-010 SHALL have port out_data, output, WIDTH+1, the head entry as {carry, sum}.
REQ-011 SHALL have port out_valid, output, 1, meaning the FIFO is non-empty.
REQ-012 SHALL have port out_ready, input, 1, the consumer accept signal.
REQ-013 SHALL have port level, output, $clog2(DEPTH)+1, the current occupancy.
REQ-014 SHALL have port full, output, 1, asserted when level equals DEPTH.
REQ-015 SHALL have port overflow, output, 1, a sticky flag for dropped writes.
REQ-016 SHALL have port carry_cnt, output, 16, the carry-set word statistic (see Configuration).

Function
REQ-017 SHALL push {c_in,s_in} when in_valid=1 and either full=0 or a pop occurs in the same cycle.
REQ-018 SHALL pop when out_valid=1 and out_ready=1; out_data SHALL present the next entry in the cycle after the pop edge.
REQ-019 SHALL have out_data as a combinational read of the head entry; a word pushed at edge N SHALL be visible at out_valid/out_data after edge N, with no fall-through in the same cycle.
REQ-020 Simultaneous push and pop, not full: level SHALL be unchanged and both operations SHALL take effect.
REQ-021 Simultaneous push and pop when full: the push SHALL be accepted, level SHALL stay DEPTH and overflow SHALL stay unchanged.
REQ-022 Push when full with no pop: the word SHALL be dropped, stored data SHALL be unchanged, and overflow SHALL be set, staying set until clr or reset.
REQ-023 Push when empty: out_valid SHALL be 0 in that cycle and no pop SHALL occur.
REQ-024 Read and write pointers SHALL be $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full/empty SHALL be decoded from MSB inequality and LSB equality.
REQ-025 clr=1 SHALL empty the FIFO and clear overflow and carry_cnt at the next edge, with priority over push and pop in that cycle.
REQ-026 out_data SHALL be don't-care while out_valid=0; the bench SHALL NOT check it.

Reset
REQ-027 rst_n=0 SHALL immediately force the following, regardless of clk: level=0, out_valid=0, full=0, overflow=0, carry_cnt=0, pointers=0.
REQ-028 Storage contents SHALL NOT be reset.
REQ-029 Reset asserted mid-burst SHALL discard all entries; the first push after rst_n rises SHALL land in entry 0.

Configuration
REQ-030 SHALL define macro ADDER_FIFO_CARRY_STATS_EN.
REQ-031 With the macro defined: carry_cnt SHALL increment on each accepted push with c_in=1, saturate at 16'hFFFF, and clear on clr or reset.
REQ-032 Without the macro: carry_cnt SHALL be tied to 0 and no counter logic SHALL be present.

Structure
REQ-033 Shared package adder_pkg SHALL hold the default WIDTH constant and the parameterised result-word layout (carry bit at MSB).
REQ-034 SHALL have one sub-module, adder_fifo_mem, a DEPTH x (WIDTH+1) register array with a single write port and a single asynchronous read port; pointer/flag logic SHALL stay in the top module.

Verification (WIDTH=8, DEPTH=4)
REQ-035 Push 8'h2A/c=0, then 8'hFF/c=1, with out_ready=0: level=2, out_data=9'h02A; after one pop, out_data=9'h1FF.
REQ-036 Five consecutive pushes with out_ready=0: full=1 after the 4th push; the 5th is dropped and overflow=1; popping 4 returns the first 4 words in order.
REQ-037 Full, then in_valid=1 and out_ready=1 held for 6 cycles: level stays 4, overflow stays 0, and the pop order matches the push order across pointer wrap.
REQ-038 rst_n pulsed low for 3 ns between clock edges with level=3: outputs are zero immediately; the next push of 8'h55 appears as out_data=9'h055 with level=1.
REQ-039 clr=1 together with in_valid=1: level=0 and overflow=0 after the edge, and the word is not stored.
REQ-040 With the macro defined, 10 pushes with c_in=1 (draining concurrently) give carry_cnt=10; without the macro, carry_cnt=0.
